shift_reg: RTL and testbench

SHIFT_REG -- requirements
Module: shift_reg

---
 rtl/shift_reg.sv | 69 ++++++
 tb/tb_shift_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// shift_reg: fixed combinational left shift plus a registered
// SLL/SRL/SRA/ROTR shifter with a one-cycle result-valid strobe.
module shift_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHAMT = 2,
  localparam int unsigned AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_shift,
  output logic [WIDTH-1:0] out_shift,
  input  logic             en,
  input  logic [1:0]       sh_op,
  input  logic [AW-1:0]    sh_amt,
  output logic [WIDTH-1:0] sh_result,
  output logic             sh_valid
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  logic [WIDTH-1:0]        op_res;
  logic signed [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0]        sh_result_d, sh_result_q;
  logic                    sh_valid_d, sh_valid_q;

  // Fixed left shift; independent of clock, reset and the registered path.
  assign out_shift = in_shift << SHAMT;

  // Selected shift operation on the current operand.
  always_comb begin
    op_res  = in_shift;
    sra_res = $signed(in_shift) >>> sh_amt;
    case (sh_op)
      OP_SLL:  op_res = in_shift << sh_amt;
      OP_SRL:  op_res = in_shift >> sh_amt;
      OP_SRA:  op_res = sra_res;
      // Left term vanishes for sh_amt=0 since a shift by WIDTH yields zero.
      OP_ROTR: op_res = (in_shift >> sh_amt) | (in_shift << (WIDTH - 32'(sh_amt)));
      default: op_res = in_shift;
    endcase
  end

  // Next state: load on en, otherwise hold the result and drop valid.
  always_comb begin
    sh_result_d = sh_result_q;
    sh_valid_d  = en;
    if (en) begin
      sh_result_d = op_res;
    end
  end

  // Result/valid registers; reset wins over en, so an en during reset is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_result_q <= '0;
      sh_valid_q  <= 1'b0;
    end else begin
      sh_result_q <= sh_result_d;
      sh_valid_q  <= sh_valid_d;
    end
  end

  assign sh_result = sh_result_q;
  assign sh_valid  = sh_valid_q;

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboard bench for shift_reg: stimulus pushes the expected post-edge
// state per cycle, an independent monitor pops and compares after each edge.
module tb_shift_reg;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] ROTR = 2'b11;

  typedef struct packed {
    logic        v;
    logic [31:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_shift;
  logic [31:0] out_shift;
  logic        en;
  logic [1:0]  sh_op;
  logic [4:0]  sh_amt;
  logic [31:0] sh_result;
  logic        sh_valid;

  exp_t        q[$];
  logic [31:0] model_r;
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;

  shift_reg #(.WIDTH(32), .SHAMT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_shift  (in_shift),
    .out_shift (out_shift),
    .en        (en),
    .sh_op     (sh_op),
    .sh_amt    (sh_amt),
    .sh_result (sh_result),
    .sh_valid  (sh_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and record what the DUT must show after the edge.
  task automatic drive(input logic rst, input logic e, input logic [1:0] op,
                       input logic [4:0] amt, input logic [31:0] din,
                       input logic [31:0] exp_r);
    exp_t x;
    @(negedge clk);
    reset_n  = rst;
    en       = e;
    sh_op    = op;
    sh_amt   = amt;
    in_shift = din;
    if (!rst) begin
      model_r = 32'h0;
      x.v     = 1'b0;
    end else if (e) begin
      model_r = exp_r;
      x.v     = 1'b1;
    end else begin
      x.v     = 1'b0;
    end
    x.r = model_r;
    q.push_back(x);
  endtask

  // Combinational path check, taken mid-cycle away from any clock edge.
  task automatic comb_check(input logic [31:0] din, input logic [31:0] exp_o);
    @(negedge clk);
    #2;
    in_shift = din;
    #1;
    checks++;
    if (out_shift !== exp_o) begin
      errors++;
      $display("FAIL out_shift in=%h: got %h, required %h", din, out_shift, exp_o);
    end
  endtask

  // Monitor: compare valid and result against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (sh_valid !== x.v || sh_result !== x.r) begin
          errors++;
          $display("FAIL edge%0d: valid=%b result=%h, required valid=%b result=%h",
                   cyc, sh_valid, sh_result, x.v, x.r);
        end
      end
    end
  end

  initial begin
    int budget;
    model_r  = 32'h0;
    reset_n  = 1'b0;
    en       = 1'b0;
    sh_op    = SLL;
    sh_amt   = 5'd0;
    in_shift = 32'h0;

    // Reset, with en held high on the second reset edge.
    drive(1'b0, 1'b0, SLL, 5'd0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, SRA, 5'd4, 32'h8000_0000, 32'h0);
    comb_check(32'h0000_000F, 32'h0000_003C);
    reset_n = 1'b1;
    en      = 1'b0;

    // Combinational path.
    comb_check(32'hFFFF_FFFF, 32'hFFFF_FFFC);
    comb_check(32'h0000_000C, 32'h0000_0030);

    // SRA then hold.
    drive(1'b1, 1'b1, SRA, 5'd4, 32'h8000_0000, 32'hF800_0000);
    drive(1'b1, 1'b0, SLL, 5'd1, 32'h1234_5678, 32'h0);

    // All ops back to back.
    drive(1'b1, 1'b1, SLL,  5'd8, 32'h1234_5678, 32'h3456_7800);
    drive(1'b1, 1'b1, SRL,  5'd8, 32'h1234_5678, 32'h0012_3456);
    drive(1'b1, 1'b1, SRA,  5'd8, 32'h1234_5678, 32'h0012_3456);
    drive(1'b1, 1'b1, ROTR, 5'd8, 32'h1234_5678, 32'h7812_3456);

    // Zero shift amount.
    drive(1'b1, 1'b1, SLL,  5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, SRL,  5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, SRA,  5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, ROTR, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Maximum shift amount.
    drive(1'b1, 1'b1, SLL,  5'd31, 32'h8000_0001, 32'h8000_0000);
    drive(1'b1, 1'b1, SRL,  5'd31, 32'h8000_0001, 32'h0000_0001);
    drive(1'b1, 1'b1, SRA,  5'd31, 32'h8000_0001, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, ROTR, 5'd31, 32'h8000_0001, 32'h0000_0003);

    // SRA with positive operand, idle, then reset with en and recovery.
    drive(1'b1, 1'b1, SRA,  5'd4, 32'h7FFF_FFF0, 32'h07FF_FFFF);
    drive(1'b1, 1'b0, ROTR, 5'd3, 32'hDEAD_BEEF, 32'h0);
    drive(1'b0, 1'b1, SLL,  5'd1, 32'h0000_0001, 32'h0);
    drive(1'b1, 1'b0, SLL,  5'd1, 32'h0000_0001, 32'h0);
    drive(1'b1, 1'b1, ROTR, 5'd4, 32'h0000_0001, 32'h1000_0000);
    drive(1'b1, 1'b0, SLL,  5'd0, 32'h0, 32'h0);
    comb_check(32'h4000_0001, 32'h0000_0004);

    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
